// File: rtl/bmu_pkg.sv
// Shared types and helpers for the pipelined bit-manipulation unit.
// Count helpers take the live width as an argument so one body serves every WIDTH up to BMU_MAX_W.
package bmu_pkg;

  localparam int BMU_NUM_OPS = 13;
  localparam int BMU_MAX_W   = 128;

  typedef struct packed {
    logic zbb;
    logic land, lor, lxor;
    logic sll, srl, sra, rol, ror;
    logic clz, ctz, cpop;
    logic min, max;
  } ap_t;

  function automatic logic [31:0] f_clz(input logic [BMU_MAX_W-1:0] x, input int w);
    logic [31:0] n;
    logic found;
    n = '0;
    found = 1'b0;
    for (int i = BMU_MAX_W - 1; i >= 0; i--) begin
      if (i < w && !found) begin
        if (x[i]) found = 1'b1;
        else n++;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] f_ctz(input logic [BMU_MAX_W-1:0] x, input int w);
    logic [31:0] n;
    logic found;
    n = '0;
    found = 1'b0;
    for (int i = 0; i < BMU_MAX_W; i++) begin
      if (i < w && !found) begin
        if (x[i]) found = 1'b1;
        else n++;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] f_cpop(input logic [BMU_MAX_W-1:0] x, input int w);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < BMU_MAX_W; i++) begin
      if (i < w && x[i]) n++;
    end
    return n;
  endfunction

  function automatic logic f_onehot_check(input logic [BMU_NUM_OPS-1:0] v);
    return $countones(v) == 1;
  endfunction

endpackage

// File: rtl/bmu_alu.sv
// Combinational datapath: decodes the one-hot op, flags illegal encodings, computes the result.
// Illegal requests always produce a zero result so nothing stale leaks to writeback.
module bmu_alu
  import bmu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  ap_t              ap,
  input  logic             csrRenIn,
  input  logic [WIDTH-1:0] csrRdataIn,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  logic [BMU_NUM_OPS-1:0] w_ops;
  logic [SHW-1:0]         w_amt;
  logic [WIDTH-1:0]       w_b_op;
  logic [WIDTH-1:0]       w_rol;
  logic [WIDTH-1:0]       w_ror;
  logic                   w_lt;
  logic                   w_zbb_ok;

  assign w_ops  = ap[BMU_NUM_OPS-1:0];
  assign w_amt  = bIn[SHW-1:0];
  assign w_b_op = ap.zbb ? ~bIn : bIn;
  // Shifting by the full width yields zero, so rotate-by-0 falls out as identity.
  assign w_rol  = (aIn << w_amt) | (aIn >> (WIDTH - int'(w_amt)));
  assign w_ror  = (aIn >> w_amt) | (aIn << (WIDTH - int'(w_amt)));
  assign w_lt   = ap.zbb ? (aIn < bIn) : ($signed(aIn) < $signed(bIn));

  assign w_zbb_ok = !ap.zbb ||
                    (!csrRenIn && (ap.land || ap.lor || ap.lxor || ap.min || ap.max));
  assign illegal  = (csrRenIn ? (|w_ops) : !f_onehot_check(w_ops)) || !w_zbb_ok;

  always_comb begin
    result = '0;
    if (!illegal) begin
      if (csrRenIn) begin
        result = csrRdataIn;
      end else begin
        case (1'b1)
          ap.land: result = aIn & w_b_op;
          ap.lor:  result = aIn | w_b_op;
          ap.lxor: result = aIn ^ w_b_op;
          ap.sll:  result = aIn << w_amt;
          ap.srl:  result = aIn >> w_amt;
          ap.sra:  result = $signed(aIn) >>> w_amt;
          ap.rol:  result = w_rol;
          ap.ror:  result = w_ror;
          ap.clz:  result = WIDTH'(f_clz(BMU_MAX_W'(aIn), WIDTH));
          ap.ctz:  result = WIDTH'(f_ctz(BMU_MAX_W'(aIn), WIDTH));
          ap.cpop: result = WIDTH'(f_cpop(BMU_MAX_W'(aIn), WIDTH));
          ap.min:  result = w_lt ? aIn : bIn;
          ap.max:  result = w_lt ? bIn : aIn;
          default: result = '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/bmu_pipeline.sv
// Pipelined BMU: ALU feeds PIPE_DEPTH handshaked register stages with bubble-collapsing flow control.
// Also keeps a saturating count of accepted illegal ops.
module bmu_pipeline
  import bmu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scanMode,
  input  logic                 validIn,
  output logic                 readyOut,
  input  ap_t                  ap,
  input  logic                 csrRenIn,
  input  logic [WIDTH-1:0]     csrRdataIn,
  input  logic [WIDTH-1:0]     aIn,
  input  logic [WIDTH-1:0]     bIn,
  output logic                 validOut,
  input  logic                 readyIn,
  output logic [WIDTH-1:0]     resultOut,
  output logic                 errorOut,
  output logic [ERR_CNT_W-1:0] errCnt
);

  localparam int LAST = PIPE_DEPTH - 1;

  logic [PIPE_DEPTH-1:0] r_vld;
  logic [PIPE_DEPTH-1:0] r_err;
  logic [WIDTH-1:0]      r_res [PIPE_DEPTH];
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  logic [PIPE_DEPTH-1:0] w_load;
  logic [PIPE_DEPTH-1:0] w_vld_in;
  logic [PIPE_DEPTH-1:0] w_err_in;
  logic [WIDTH-1:0]      w_res_in [PIPE_DEPTH];
  logic [WIDTH-1:0]      w_alu_res;
  logic                  w_alu_ill;
  logic                  w_acc;

  bmu_alu #(.WIDTH(WIDTH)) u_alu (
    .ap         (ap),
    .csrRenIn   (csrRenIn),
    .csrRdataIn (csrRdataIn),
    .aIn        (aIn),
    .bIn        (bIn),
    .result     (w_alu_res),
    .illegal    (w_alu_ill)
  );

  // A stage may load when it is empty or its content moves on this cycle.
  always_comb begin
    logic ld;
    w_load = '0;
    ld = !r_vld[LAST] || readyIn;
    w_load[LAST] = ld;
    for (int i = PIPE_DEPTH - 2; i >= 0; i--) begin
      ld = !r_vld[i] || ld;
      w_load[i] = ld;
    end
  end

  assign readyOut = !rst && !scanMode && w_load[0];
  assign w_acc    = validIn && readyOut;

  always_comb begin
    w_vld_in    = '0;
    w_err_in    = '0;
    w_res_in    = '{default: '0};
    w_vld_in[0] = w_acc;
    w_err_in[0] = w_alu_ill;
    w_res_in[0] = w_alu_res;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      w_vld_in[i] = r_vld[i-1];
      w_err_in[i] = r_err[i-1];
      w_res_in[i] = r_res[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) r_res[i] <= '0;
    end else begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        if (w_load[i]) begin
          r_vld[i] <= w_vld_in[i];
          if (w_vld_in[i]) begin
            r_res[i] <= w_res_in[i];
            r_err[i] <= w_err_in[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_acc && w_alu_ill && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign validOut  = r_vld[LAST];
  assign resultOut = r_res[LAST];
  assign errorOut  = r_vld[LAST] && r_err[LAST];
  assign errCnt    = r_err_cnt;

endmodule

// File: tb/tb_bmu_pipeline.sv
// Scoreboard bench for bmu_pipeline: driver pushes expected results on acceptance,
// monitor pops and compares whenever an output is presented.
module tb_bmu_pipeline;
  import bmu_pkg::*;

  localparam logic [13:0] OP_ZBB  = 14'h2000;
  localparam logic [13:0] OP_LAND = 14'h1000;
  localparam logic [13:0] OP_LOR  = 14'h0800;
  localparam logic [13:0] OP_LXOR = 14'h0400;
  localparam logic [13:0] OP_SLL  = 14'h0200;
  localparam logic [13:0] OP_SRL  = 14'h0100;
  localparam logic [13:0] OP_SRA  = 14'h0080;
  localparam logic [13:0] OP_ROL  = 14'h0040;
  localparam logic [13:0] OP_ROR  = 14'h0020;
  localparam logic [13:0] OP_CLZ  = 14'h0010;
  localparam logic [13:0] OP_CTZ  = 14'h0008;
  localparam logic [13:0] OP_CPOP = 14'h0004;
  localparam logic [13:0] OP_MIN  = 14'h0002;
  localparam logic [13:0] OP_MAX  = 14'h0001;

  logic        clk = 1'b0;
  logic        rst, scanMode, validIn, readyOut, csrRenIn, validOut, readyIn, errorOut;
  ap_t         ap;
  logic [31:0] csrRdataIn, aIn, bIn, resultOut;
  logic [15:0] errCnt;

  bmu_pipeline #(.WIDTH(32), .PIPE_DEPTH(2), .ERR_CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .scanMode   (scanMode),
    .validIn    (validIn),
    .readyOut   (readyOut),
    .ap         (ap),
    .csrRenIn   (csrRenIn),
    .csrRdataIn (csrRdataIn),
    .aIn        (aIn),
    .bIn        (bIn),
    .validOut   (validOut),
    .readyIn    (readyIn),
    .resultOut  (resultOut),
    .errorOut   (errorOut),
    .errCnt     (errCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  typedef struct {
    logic [13:0] op;
    logic        csr;
    logic [31:0] csrd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b1;
  int   exp_errcnt = 0;

  vec_t vt [28] = '{
    '{OP_LAND,          1'b0, 32'h0, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0},
    '{OP_LAND | OP_ZBB, 1'b0, 32'h0, 32'hF0F000FF, 32'h0FF00F0F, 32'hF00000F0, 1'b0},
    '{OP_SRA,           1'b0, 32'h0, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0},
    '{OP_SRA,           1'b0, 32'h0, 32'h40000000, 32'h00000001, 32'h20000000, 1'b0},
    '{OP_ROR,           1'b0, 32'h0, 32'h00000001, 32'h00000001, 32'h80000000, 1'b0},
    '{OP_CLZ,           1'b0, 32'h0, 32'h00010000, 32'h0,        32'h0000000F, 1'b0},
    '{OP_CLZ,           1'b0, 32'h0, 32'h00000000, 32'h0,        32'h00000020, 1'b0},
    '{OP_CPOP,          1'b0, 32'h0, 32'hFFFFFFFF, 32'h0,        32'h00000020, 1'b0},
    '{OP_MIN,           1'b0, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0},
    '{OP_MIN | OP_ZBB,  1'b0, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0},
    '{OP_LAND | OP_LXOR,1'b0, 32'h0, 32'hF0F000FF, 32'h0FF00F0F, 32'h00000000, 1'b1},
    '{14'h0,            1'b1, 32'hDEADBEEF, 32'h0,   32'h0,        32'hDEADBEEF, 1'b0},
    '{OP_LOR,           1'b0, 32'h0, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0},
    '{OP_LOR | OP_ZBB,  1'b0, 32'h0, 32'h00000000, 32'hFFFF0000, 32'h0000FFFF, 1'b0},
    '{OP_LXOR | OP_ZBB, 1'b0, 32'h0, 32'hFFFF0000, 32'hFF00FF00, 32'hFF0000FF, 1'b0},
    '{OP_SLL,           1'b0, 32'h0, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0},
    '{OP_SRL,           1'b0, 32'h0, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0},
    '{OP_ROL,           1'b0, 32'h0, 32'h80000001, 32'h00000004, 32'h00000018, 1'b0},
    '{OP_ROR,           1'b0, 32'h0, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0},
    '{OP_CTZ,           1'b0, 32'h0, 32'h00000100, 32'h0,        32'h00000008, 1'b0},
    '{OP_CTZ,           1'b0, 32'h0, 32'h00000000, 32'h0,        32'h00000020, 1'b0},
    '{OP_CPOP,          1'b0, 32'h0, 32'h0F0F0001, 32'h0,        32'h00000009, 1'b0},
    '{OP_MAX,           1'b0, 32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0},
    '{OP_MAX | OP_ZBB,  1'b0, 32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b0},
    '{14'h0,            1'b0, 32'h0, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1},
    '{OP_LAND,          1'b1, 32'hDEADBEEF, 32'h1,   32'h1,        32'h00000000, 1'b1},
    '{OP_SLL | OP_ZBB,  1'b0, 32'h0, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1},
    '{OP_ZBB,           1'b1, 32'hDEADBEEF, 32'h0,   32'h0,        32'h00000000, 1'b1}
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && validOut) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output actual=%h err=%b required=none", resultOut, errorOut);
      end else begin
        e = sb[0];
        chk("result", resultOut, e.res);
        chk("error", 32'(errorOut), 32'(e.err));
        if (readyIn) begin
          if (e.chk_lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [13:0] op, input logic csr, input logic [31:0] csrd,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input logic exp_err);
    int t = 0;
    bit ok = 1'b0;
    ap = ap_t'(op);
    csrRenIn = csr;
    csrRdataIn = csrd;
    aIn = a;
    bIn = b;
    validIn = 1'b1;
    while (!ok && t < 100) begin
      @(negedge clk);
      if (readyOut) begin
        ok = 1'b1;
        sb.push_back('{res: exp_res, err: exp_err, acc_cyc: cyc, chk_lat: lat_chk});
        if (exp_err) exp_errcnt++;
      end
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
    validIn = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || validOut) && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    scanMode = 1'b0;
    validIn = 1'b0;
    readyIn = 1'b1;
    ap = '0;
    csrRenIn = 1'b0;
    csrRdataIn = '0;
    aIn = '0;
    bIn = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_validOut", 32'(validOut), 32'd0);
    chk("rst_readyOut", 32'(readyOut), 32'd0);
    chk("rst_resultOut", resultOut, 32'h0);
    chk("rst_errorOut", 32'(errorOut), 32'd0);
    chk("rst_errCnt", 32'(errCnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_readyOut", 32'(readyOut), 32'd1);
    @(posedge clk);
    #1;

    foreach (vt[i]) send(vt[i].op, vt[i].csr, vt[i].csrd, vt[i].a, vt[i].b, vt[i].res, vt[i].err);
    drain();
    chk("errCnt_after_table", 32'(errCnt), 32'(exp_errcnt));

    send(OP_LOR, 1'b0, 32'h0, 32'h00000003, 32'h0000000C, 32'h0000000F, 1'b0);
    scanMode = 1'b1;
    @(negedge clk);
    chk("scan_readyOut", 32'(readyOut), 32'd0);
    drain();
    scanMode = 1'b0;

    lat_chk = 1'b0;
    readyIn = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1;
        readyIn = 1'b1;
      end
    join_none
    send(OP_LAND, 1'b0, 32'h0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0);
    send(OP_SLL,  1'b0, 32'h0, 32'h00000003, 32'h00000004, 32'h00000030, 1'b0);
    @(negedge clk);
    chk("bp_readyOut_low", 32'(readyOut), 32'd0);
    @(posedge clk);
    #1;
    send(OP_CPOP, 1'b0, 32'h0, 32'h000000FF, 32'h0,        32'h00000008, 1'b0);
    send(OP_SRA,  1'b0, 32'h0, 32'hF0000000, 32'h00000008, 32'hFFF00000, 1'b0);
    drain();
    lat_chk = 1'b1;

    send(OP_LOR | OP_LXOR, 1'b0, 32'h0, 32'h1, 32'h2, 32'h0, 1'b1);
    send(OP_CLZ | OP_ZBB,  1'b0, 32'h0, 32'h1, 32'h2, 32'h0, 1'b1);
    chk("pre_rst_validOut", 32'(validOut), 32'd1);
    chk("pre_rst_errCnt", 32'(errCnt), 32'(exp_errcnt));
    rst = 1'b1;
    sb.delete();
    exp_errcnt = 0;
    #1;
    chk("async_rst_validOut", 32'(validOut), 32'd0);
    chk("async_rst_errCnt", 32'(errCnt), 32'd0);
    chk("async_rst_readyOut", 32'(readyOut), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(OP_LAND, 1'b0, 32'h0, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0);
    drain();
    chk("final_errCnt", 32'(errCnt), 32'(exp_errcnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
